depp_wb_bridge: RTL and testbench

//  Bridges a Digilent DEPP 8-bit parallel port (host/USB side) to a 32-bit

---
 rtl/depp_wb_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_depp_wb_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depp_wb_bridge.sv
// Digilent DEPP 8-bit parallel port to 32-bit pipelined Wishbone master bridge.
// Optional feature: define DEPP_AUTOINC_EN to post-increment the WB address after each acked transaction.
module depp_wb_bridge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_astb_n,
   input  logic        i_dstb_n,
   input  logic        i_write_n,
   input  logic [7:0]  i_depp,
   output logic [7:0]  o_depp,
   output logic        o_wait,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   input  logic [31:0] i_wb_data,
   input  logic        i_int
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;
   localparam logic [BW-1:0] REG_ADDR_LAST = 8'd3;
   localparam logic [BW-1:0] REG_DATA_LAST = 8'd7;
   localparam logic [BW-1:0] REG_STATUS    = 8'd8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_DONE,
      S_HOLD
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0]         astb_sr;
   logic [SYNC_STAGES-1:0]         dstb_sr;
   logic [SYNC_STAGES-1:0]         wrn_sr;
   logic [SYNC_STAGES-1:0][BW-1:0] depp_sr;
   logic                           astb_prev;
   logic                           dstb_prev;

   logic [BW-1:0] ptr;
   logic [DW-1:0] rdata;
   logic          err_flag;
   logic          int_flag;

   logic          astb_s;
   logic          dstb_s;
   logic          wrn_s;
   logic [BW-1:0] host_data;
   logic          addr_evt;
   logic          data_evt;
   logic          launch;
   logic          status_rd;
   logic [1:0]    lane;
   logic [BW-1:0] rd_byte;

   // Synchronize the asynchronous DEPP pins; strobes idle high
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         astb_sr   <= '1;
         dstb_sr   <= '1;
         wrn_sr    <= '1;
         depp_sr   <= '0;
         astb_prev <= 1'b1;
         dstb_prev <= 1'b1;
      end else begin
         astb_sr   <= {astb_sr[SYNC_STAGES-2:0], i_astb_n};
         dstb_sr   <= {dstb_sr[SYNC_STAGES-2:0], i_dstb_n};
         wrn_sr    <= {wrn_sr[SYNC_STAGES-2:0], i_write_n};
         depp_sr   <= {depp_sr[SYNC_STAGES-2:0], i_depp};
         astb_prev <= astb_sr[SYNC_STAGES-1];
         dstb_prev <= dstb_sr[SYNC_STAGES-1];
      end
   end

   assign astb_s    = astb_sr[SYNC_STAGES-1];
   assign dstb_s    = dstb_sr[SYNC_STAGES-1];
   assign wrn_s     = wrn_sr[SYNC_STAGES-1];
   assign host_data = depp_sr[SYNC_STAGES-1];

   // Address strobe wins if both strobes fall together
   assign addr_evt  = astb_prev & ~astb_s;
   assign data_evt  = dstb_prev & ~dstb_s & ~addr_evt;
   assign launch    = data_evt & ~wrn_s & ((ptr == REG_ADDR_LAST) || (ptr == REG_DATA_LAST));
   assign status_rd = (state == S_IDLE) & data_evt & wrn_s & (ptr == REG_STATUS);
   assign lane      = 2'd3 - ptr[1:0];

   // Host-visible register readback; data bytes return the last WB read result
   always_comb begin
      rd_byte = '0;
      if (ptr <= REG_ADDR_LAST) begin
         rd_byte = o_wb_addr[{lane, 3'b000} +: BW];
      end else if (ptr <= REG_DATA_LAST) begin
         rd_byte = rdata[{lane, 3'b000} +: BW];
      end else if (ptr == REG_STATUS) begin
         rd_byte = {5'b0, int_flag, err_flag, o_wb_cyc};
      end
   end

   // Host handshake and Wishbone master sequencing
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         o_depp    <= '0;
         o_wait    <= 1'b0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
         ptr       <= '0;
         rdata     <= '0;
         err_flag  <= 1'b0;
         int_flag  <= 1'b0;
      end else begin
         // A pending interrupt beats the clear from a concurrent status read
         int_flag <= i_int | (int_flag & ~status_rd);
         if (status_rd) begin
            err_flag <= 1'b0;
         end

         unique case (state)
            S_IDLE: begin
               if (addr_evt) begin
                  if (!wrn_s) begin
                     ptr <= host_data;
                  end else begin
                     o_depp <= ptr;
                  end
                  o_wait <= 1'b1;
                  state  <= S_HOLD;
               end else if (data_evt) begin
                  if (!wrn_s) begin
                     if (ptr <= REG_ADDR_LAST) begin
                        o_wb_addr[{lane, 3'b000} +: BW] <= host_data;
                     end else if (ptr <= REG_DATA_LAST) begin
                        o_wb_data[{lane, 3'b000} +: BW] <= host_data;
                     end
                  end else begin
                     o_depp <= rd_byte;
                  end
                  if (launch) begin
                     o_wb_cyc <= 1'b1;
                     o_wb_stb <= 1'b1;
                     o_wb_we  <= ptr[2];
                     state    <= S_BUS;
                  end else begin
                     o_wait <= 1'b1;
                     state  <= S_HOLD;
                  end
               end
            end

            S_BUS: begin
               if (o_wb_stb && !i_wb_stall) begin
                  o_wb_stb <= 1'b0;
               end
               if (i_wb_ack || i_wb_err) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  if (i_wb_err) begin
                     err_flag <= 1'b1;
                  end else begin
                     if (!o_wb_we) begin
                        rdata <= i_wb_data;
                     end
`ifdef DEPP_AUTOINC_EN
                     o_wb_addr <= o_wb_addr + AW'(1);
`else
                     o_wb_addr <= o_wb_addr;
`endif
                  end
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               o_wait <= 1'b1;
               state  <= S_HOLD;
            end

            S_HOLD: begin
               if (astb_s && dstb_s) begin
                  o_wait <= 1'b0;
                  state  <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_depp_wb_bridge.sv
// Self-checking bench for depp_wb_bridge: host register table, Wishbone slave
// model with scoreboard, stall/error/interrupt/reset corner sequences.
module tb_depp_wb_bridge;

`ifdef DEPP_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        astb_n = 1'b1;
   logic        dstb_n = 1'b1;
   logic        write_n = 1'b1;
   logic [7:0]  depp_in = 8'h00;
   logic [7:0]  depp_out;
   logic        wait_o;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [31:0] wb_addr;
   logic [31:0] wb_wdata;
   logic        wb_ack = 1'b0;
   logic        wb_stall = 1'b0;
   logic        wb_err = 1'b0;
   logic [31:0] wb_rdata = 32'h0;
   logic        irq = 1'b0;

   always #5 clk = ~clk;

   depp_wb_bridge #(.SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_astb_n(astb_n), .i_dstb_n(dstb_n), .i_write_n(write_n),
      .i_depp(depp_in), .o_depp(depp_out), .o_wait(wait_o),
      .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
      .o_wb_addr(wb_addr), .o_wb_data(wb_wdata),
      .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
      .i_wb_data(wb_rdata), .i_int(irq)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } wb_txn_t;

   typedef struct {
      logic       is_addr;
      logic       rd;
      logic [7:0] wdata;
      logic       chk;
      logic [7:0] exp;
      string      name;
   } vec_t;

   wb_txn_t    wb_q[$];
   logic [7:0] rd_q[$];

   int          stall_cfg = 0;
   logic        err_cfg = 1'b0;
   int          stall_seen = 0;
   logic [31:0] m_addr = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Wishbone slave: optional stall, then single-cycle ack/err; compares against scoreboard
   initial begin : wb_slave
      bit busy = 0;
      bit responded = 0;
      int stall_left = 0;
      wb_txn_t e;
      forever begin
         @(posedge clk);
         #1;
         wb_ack   = 1'b0;
         wb_err   = 1'b0;
         wb_stall = 1'b0;
         if (!wb_cyc) begin
            if (busy && responded) chk("wait_low_after_cyc", 32'(wait_o), 32'h0);
            busy = 0;
            responded = 0;
         end else if (wb_stb) begin
            if (!busy) begin
               busy = 1;
               stall_left = stall_cfg;
            end
            if (stall_left > 0) begin
               wb_stall = 1'b1;
               stall_left--;
               stall_seen++;
            end else begin
               chk("wait_low_busy", 32'(wait_o), 32'h0);
               if (wb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL wb_unexpected: got addr 0x%08h we %0b, none expected", wb_addr, wb_we);
               end else begin
                  e = wb_q.pop_front();
                  chk("wb_we", 32'(wb_we), 32'(e.we));
                  chk("wb_addr", wb_addr, e.addr);
                  if (e.we) chk("wb_wdata", wb_wdata, e.data);
               end
               if (err_cfg) wb_err = 1'b1;
               else wb_ack = 1'b1;
               responded = 1;
            end
         end
      end
   end

   task automatic xfer(input logic is_addr, input logic rd, input logic [7:0] wd,
                       output logic [7:0] rdv);
      int n;
      @(negedge clk);
      write_n = rd;
      depp_in = wd;
      @(negedge clk);
      if (is_addr) astb_n = 1'b0;
      else dstb_n = 1'b0;
      n = 0;
      while (!wait_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!wait_o) begin
         errors++;
         $display("FAIL wait_rise_timeout: got o_wait=0 expected 1");
      end
      rdv = depp_out;
      astb_n = 1'b1;
      dstb_n = 1'b1;
      n = 0;
      while (wait_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (wait_o) begin
         errors++;
         $display("FAIL wait_fall_timeout: got o_wait=1 expected 0");
      end
      write_n = 1'b1;
   endtask

   task automatic wr_reg(input logic [7:0] p, input logic [7:0] v);
      logic [7:0] d;
      xfer(1'b1, 1'b0, p, d);
      xfer(1'b0, 1'b0, v, d);
   endtask

   task automatic rd_chk(input logic [7:0] p, input logic [7:0] exp, input string name);
      logic [7:0] d;
      rd_q.push_back(exp);
      xfer(1'b1, 1'b0, p, d);
      xfer(1'b0, 1'b1, 8'h00, d);
      chk(name, 32'(d), 32'(rd_q.pop_front()));
   endtask

   initial begin : main
      vec_t vecs[$];
      logic [7:0] d;
      int n;

      vecs.push_back('{1'b1, 1'b0, 8'h03, 1'b0, 8'h00, "ptr_w3"});
      vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 8'h03, "ptr_rd3"});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "reg3_reset"});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b0, 8'h12, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b1, 1'b0, 8'h01, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b0, 8'h34, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b1, 1'b0, 8'h02, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b0, 8'h56, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h12, "reg0"});
      vecs.push_back('{1'b1, 1'b0, 8'h02, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h56, "reg2"});
      vecs.push_back('{1'b1, 1'b0, 8'h09, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b0, 8'hAA, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "reg9"});
      vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 8'h09, "ptr_rd9"});
      vecs.push_back('{1'b1, 1'b0, 8'h08, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "status_idle"});
      vecs.push_back('{1'b1, 1'b0, 8'h04, 1'b0, 8'h00, ""});
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, "reg4_reset"});

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wait", 32'(wait_o), 32'h0);
      chk("rst_cyc", 32'(wb_cyc), 32'h0);
      chk("rst_stb", 32'(wb_stb), 32'h0);
      chk("rst_we", 32'(wb_we), 32'h0);
      chk("rst_addr", wb_addr, 32'h0);
      chk("rst_wdata", wb_wdata, 32'h0);
      chk("rst_depp", 32'(depp_out), 32'h0);

      // Register access table
      foreach (vecs[i]) begin
         if (vecs[i].chk) rd_q.push_back(vecs[i].exp);
         xfer(vecs[i].is_addr, vecs[i].rd, vecs[i].wdata, d);
         if (vecs[i].chk) chk(vecs[i].name, 32'(d), 32'(rd_q.pop_front()));
      end

      // WB read at 0x12345678 returning 0xDEADBEEF
      wb_rdata = 32'hDEADBEEF;
      m_addr = 32'h12345678;
      wb_q.push_back('{1'b0, m_addr, 32'h0});
      wr_reg(8'h03, 8'h78);
      if (AUTOINC) m_addr = m_addr + 32'd1;
      rd_chk(8'h04, 8'hDE, "rdback4");
      rd_chk(8'h05, 8'hAD, "rdback5");
      rd_chk(8'h06, 8'hBE, "rdback6");
      rd_chk(8'h07, 8'hEF, "rdback7");

      // WB write of 0xCAFEF00D with 3 stall cycles
      wr_reg(8'h04, 8'hCA);
      wr_reg(8'h05, 8'hFE);
      wr_reg(8'h06, 8'hF0);
      stall_cfg = 3;
      stall_seen = 0;
      wb_q.push_back('{1'b1, m_addr, 32'hCAFEF00D});
      wr_reg(8'h07, 8'h0D);
      chk("stall_cycles", 32'(stall_seen), 32'd3);
      if (AUTOINC) m_addr = m_addr + 32'd1;
      stall_cfg = 0;
      chk("wb_q_empty_wr", 32'(wb_q.size()), 32'd0);

      // WB read that errors: sticky err, readback unchanged, no address bump
      wr_reg(8'h00, 8'h00);
      wr_reg(8'h01, 8'h00);
      wr_reg(8'h02, 8'h00);
      m_addr = 32'h00000010;
      err_cfg = 1'b1;
      wb_q.push_back('{1'b0, m_addr, 32'h0});
      wr_reg(8'h03, 8'h10);
      err_cfg = 1'b0;
      rd_chk(8'h08, 8'h02, "status_err");
      rd_chk(8'h08, 8'h00, "status_err_clr");
      rd_chk(8'h04, 8'hDE, "err_rdback4");
      rd_chk(8'h07, 8'hEF, "err_rdback7");
      rd_chk(8'h03, 8'h10, "err_addr_held");

      // Single-cycle interrupt pulse
      @(negedge clk);
      irq = 1'b1;
      @(negedge clk);
      irq = 1'b0;
      rd_chk(8'h08, 8'h04, "status_int");
      rd_chk(8'h08, 8'h00, "status_int_clr");

      // Two back-to-back writes at 0x10
      wb_q.push_back('{1'b1, m_addr, 32'hCAFEF00D});
      wr_reg(8'h07, 8'h0D);
      if (AUTOINC) m_addr = m_addr + 32'd1;
      wb_q.push_back('{1'b1, m_addr, 32'hCAFEF00D});
      xfer(1'b0, 1'b0, 8'h0D, d);
      if (AUTOINC) m_addr = m_addr + 32'd1;
      chk("wb_q_empty_inc", 32'(wb_q.size()), 32'd0);
      rd_chk(8'h03, m_addr[7:0], "addr_after_writes");

      // Reset asserted while a stalled transaction is in flight
      stall_cfg = 1000;
      xfer(1'b1, 1'b0, 8'h07, d);
      @(negedge clk);
      write_n = 1'b0;
      depp_in = 8'h55;
      @(negedge clk);
      dstb_n = 1'b0;
      n = 0;
      while (!wb_cyc && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cyc_before_rst", 32'(wb_cyc), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_mid_cyc", 32'(wb_cyc), 32'h0);
      chk("rst_mid_stb", 32'(wb_stb), 32'h0);
      chk("rst_mid_wait", 32'(wait_o), 32'h0);
      dstb_n = 1'b1;
      write_n = 1'b1;
      stall_cfg = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd_q.push_back(8'h00);
      xfer(1'b1, 1'b1, 8'h00, d);
      chk("ptr_after_rst", 32'(d), 32'(rd_q.pop_front()));
      rd_chk(8'h00, 8'h00, "addr_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
